sklansky_pipe_adder: RTL and testbench

Parametrised, pipelined Sklansky parallel-prefix adder/subtractor with valid/ready flow control on both sides. It is the datapath-grade successor to the 4-bit combinational prefix adder. It sits between operand-producing and result-consuming blocks (ALU, accumulator, DSP chains) where a WIDTH-bit add must close timing at full clock rate. It adds subtract mode, signed-overflow and zero flags, and backpressure.

---
 rtl/sklansky_pipe_adder.sv | 139 +++++++++++++
 tb/tb_sklansky_pipe_adder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sklansky_pipe_adder.sv
// Pipelined Sklansky prefix adder/subtractor with valid/ready flow control.
// One prefix level per stage, a final stage forms sum and flags; global stall.
module sklansky_cell (
  input  logic gi,
  input  logic pi,
  input  logic gj,
  input  logic pj,
  output logic go,
  output logic po
);
  assign go = gi | (pi & gj);
  assign po = pi & pj;
endmodule

module sklansky_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int LOG2W = $clog2(WIDTH);
  localparam int LAT   = LOG2W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] pb;
    logic             c0;
    logic             a_msb;
    logic             b_msb;
  } side_t;

  logic [LOG2W-1:0][WIDTH-1:0] g_q, g_d, p_q, p_d;
  logic [LOG2W-1:0][WIDTH-1:0] gi, pi, go, po;
  side_t [LOG2W-1:0]           side_q, side_d;
  side_t                       side_in;
  logic [LAT-1:0]              vld_pipe_q, vld_pipe_d;
  logic [WIDTH-1:0]            sum_q, sum_d, bp, c_last;
  logic                        cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic                        c0, advance;

  assign advance   = ~vld_pipe_q[LAT-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe_q[LAT-1];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  assign bp      = sub ? ~b : b;
  assign c0      = sub ? ~cin : cin;
  assign side_in = '{pb: a ^ bp, c0: c0, a_msb: a[WIDTH-1], b_msb: bp[WIDTH-1]};

  // c0 is the bit -1 generate; merging it into bit 0 up front makes every
  // prefix output a true carry and leaves bit 0 with a killed propagate.
  assign gi[0] = {a[WIDTH-1:1] & bp[WIDTH-1:1], (a[0] & bp[0]) | ((a[0] ^ bp[0]) & c0)};
  assign pi[0] = {a[WIDTH-1:1] ^ bp[WIDTH-1:1], 1'b0};

  for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
    if (k > 0) begin : g_feed
      assign gi[k] = g_q[k-1];
      assign pi[k] = p_q[k-1];
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i >> k) & 1) == 1) begin : g_cmb
        localparam int J = ((i >> k) << k) - 1;
        sklansky_cell u_cell (
          .gi(gi[k][i]), .pi(pi[k][i]), .gj(gi[k][J]), .pj(pi[k][J]),
          .go(go[k][i]), .po(po[k][i])
        );
      end else begin : g_pass
        assign go[k][i] = gi[k][i];
        assign po[k][i] = pi[k][i];
      end
    end
  end

  assign c_last = {g_q[LOG2W-1][WIDTH-2:0], side_q[LOG2W-1].c0};

  always_comb begin
    g_d        = g_q;
    p_d        = p_q;
    side_d     = side_q;
    vld_pipe_d = vld_pipe_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    if (advance) begin
      g_d        = go;
      p_d        = po;
      side_d     = {side_q[LOG2W-2:0], side_in};
      vld_pipe_d = {vld_pipe_q[LAT-2:0], in_valid};
      sum_d      = '0;
      cout_d     = 1'b0;
      ovf_d      = 1'b0;
      zero_d     = 1'b0;
      if (vld_pipe_q[LAT-2]) begin
        sum_d  = side_q[LOG2W-1].pb ^ c_last;
        cout_d = g_q[LOG2W-1][WIDTH-1];
        ovf_d  = (side_q[LOG2W-1].a_msb == side_q[LOG2W-1].b_msb) &&
                 (sum_d[WIDTH-1] != side_q[LOG2W-1].a_msb);
        zero_d = ~|sum_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q        <= '0;
      p_q        <= '0;
      side_q     <= '0;
      vld_pipe_q <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      g_q        <= g_d;
      p_q        <= p_d;
      side_q     <= side_d;
      vld_pipe_q <= vld_pipe_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end
endmodule

// File: tb/tb_sklansky_pipe_adder.sv
// Directed bench for sklansky_pipe_adder at widths 8/16/32/64 with a
// reference model scoreboard on the 16-bit instance.
module tb_sklansky_pipe_adder;
  localparam int LAT = 5;

  typedef struct packed {
    logic        c;
    logic        o;
    logic        z;
    logic [15:0] s;
  } res_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 0, in_ready, cin = 0, sub = 0, out_valid, out_ready = 1;
  logic [15:0] a = '0, b = '0, sum;
  logic        cout, ovf, zero;

  logic       iv8 = 0, ir8, cin8 = 0, sub8 = 0, ov8, co8, of8, z8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic        iv32 = 0, ir32, ov32, co32, of32, z32;
  logic [31:0] a32 = '0, s32;
  logic        iv64 = 0, ir64, ov64, co64, of64, z64;
  logic [63:0] a64 = '0, s64;

  sklansky_pipe_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero));
  sklansky_pipe_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(1'b1), .sum(s8),
    .cout(co8), .ovf(of8), .zero(z8));
  sklansky_pipe_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(32'h0),
    .cin(1'b1), .sub(1'b0), .out_valid(ov32), .out_ready(1'b1), .sum(s32),
    .cout(co32), .ovf(of32), .zero(z32));
  sklansky_pipe_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(64'h0),
    .cin(1'b1), .sub(1'b0), .out_valid(ov64), .out_ready(1'b1), .sum(s64),
    .cout(co64), .ovf(of64), .zero(z64));

  int   n_chk = 0, n_err = 0, n_out = 0;
  res_t q[$];

  task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic res_t ref16(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic s);
    logic [15:0] yp;
    logic [16:0] t;
    res_t        r;
    yp  = s ? ~y : y;
    t   = {1'b0, x} + {1'b0, yp} + {16'b0, s ? ~ci : ci};
    r.c = t[16];
    r.s = t[15:0];
    r.o = (x[15] == yp[15]) && (t[15] != x[15]);
    r.z = (t[15:0] == 16'h0);
    return r;
  endfunction

  // Called just after a falling edge with this cycle's inputs already driven.
  task automatic tick(output bit acc);
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("q_nonempty", q.size() != 0, 1);
      if (q.size() != 0) chk("res", {cout, ovf, zero, sum}, q.pop_front());
      n_out++;
    end
    if (acc) q.push_back(ref16(a, b, cin, sub));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic edge1();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0]  t8a [3] = '{8'h7F, 8'h05, 8'h00};
  logic [7:0]  t8b [3] = '{8'h01, 8'h05, 8'h01};
  logic        t8c [3] = '{1'b0, 1'b0, 1'b1};
  logic        t8s [3] = '{1'b0, 1'b1, 1'b1};
  logic [10:0] t8e [3] = '{11'h280, 11'h500, 11'h0FE};

  initial begin
    bit acc;
    #1;
    chk("rst_ovld", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf, zero}, 0);
    chk("rst_rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      a8 = t8a[v]; b8 = t8b[v]; cin8 = t8c[v]; sub8 = t8s[v]; iv8 = 1;
      edge1();
      iv8 = 0;
      repeat (2) edge1();
      chk("w8_early", ov8, 0);
      edge1();
      chk("w8_vld", ov8, 1);
      chk("w8_res", {co8, of8, z8, s8}, t8e[v]);
      chk("w8_rdy", ir8, 1);
    end

    a32 = '1; a64 = '1; iv32 = 1; iv64 = 1;
    edge1();
    iv32 = 0; iv64 = 0;
    repeat (4) edge1();
    chk("w32_early", ov32, 0);
    edge1();
    chk("w32_vld", ov32, 1);
    chk("w32_res", {co32, of32, z32, s32}, {3'b101, 32'h0});
    chk("w64_early", ov64, 0);
    edge1();
    chk("w64_vld", ov64, 1);
    chk("w64_res", {co64, of64, z64, s64}, {3'b101, 64'h0});
    chk("wide_rdy", {ir32, ir64}, 2'b11);

    n_out = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      in_valid = 1;
      if (i >= LAT) chk("thru", out_valid, 1);
      tick(acc);
    end
    in_valid = 0;
    repeat (LAT + 1) tick(acc);
    chk("rnd_count", n_out, 1000);
    chk("rnd_drain", q.size(), 0);

    begin
      int i = 0;
      n_out = 0;
      for (int c = 0; c < 80 && n_out < 10; c++) begin
        out_ready = !(c >= 5 && c < 12);
        in_valid  = (i < 10);
        a   = 16'(i * 16'h1234 + 16'h00F0);
        b   = 16'(16'h8000 - i * 16'h0111);
        cin = 1'((i >> 1) & 1);
        sub = 1'(i & 1);
        if (!out_ready) begin
          #1;
          chk("bp_ovld", out_valid, 1);
          chk("bp_rdy", in_ready, 0);
          if (q.size() != 0) chk("bp_hold", {cout, ovf, zero, sum}, q[0]);
        end
        tick(acc);
        if (acc) i++;
      end
      out_ready = 1;
      in_valid  = 0;
      chk("bp_count", n_out, 10);
      chk("bp_acc", i, 10);
      chk("bp_q", q.size(), 0);
    end

    for (int i = 0; i < 6; i++) begin
      a = 16'(i * 16'h0101 + 16'h0001); b = 16'h0003; cin = 0; sub = 0; in_valid = 1;
      tick(acc);
    end
    in_valid = 0;
    chk("pre_rst_vld", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_rdy", in_ready, 1);
    @(posedge clk);
    #2 rst_n = 1;
    q.delete();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("no_stale", out_valid, 0);
      tick(acc);
    end
    a = 16'hFFFF; b = 16'h0001; cin = 0; sub = 0; in_valid = 1;
    tick(acc);
    in_valid = 0;
    repeat (3) tick(acc);
    chk("lat_early", out_valid, 0);
    tick(acc);
    chk("lat_vld", out_valid, 1);
    chk("lat_res", {cout, ovf, zero, sum}, {3'b101, 16'h0});
    tick(acc);
    chk("lat_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
